// File: rtl/sum_shift_decomposer.sv
// sum_shift_decomposer
// Recovers the canonical greedy digits s3/s2/s1 of a packed value
// V = s1 + 4*s2 + 16*s3 (digits 4 bits each) by restoring subtraction,
// one trial bit per clock: twelve trials, most significant weight first.
// Whatever the greedy pass cannot absorb is reported as residue.
// valid/ready handshakes on both the input and the result side.
// WIDTH must be at least 8 so that every trial weight (up to 2^7) fits.

module sum_shift_decomposer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       s3,
  output logic [3:0]       s2,
  output logic [3:0]       s1,
  output logic [WIDTH-1:0] residue,
  output logic             exact
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [3:0] LAST_STEP = 4'd11;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] rem_next;
  logic [3:0]       step;
  logic [3:0]       step_next;
  logic [3:0]       dig3;
  logic [3:0]       dig2;
  logic [3:0]       dig1;
  logic [3:0]       dig3_next;
  logic [3:0]       dig2_next;
  logic [3:0]       dig1_next;

  // trial datapath signals
  logic [1:0]       digit_sel;
  logic [1:0]       bit_sel;
  logic [2:0]       shift_k;
  logic [3:0]       weight_pos;
  logic [WIDTH:0]   weight;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [3:0]       bit_mask;

  // Trial subtraction for the current step: which digit, which bit, and
  // whether rem can absorb that bit's weight (no borrow out of WIDTH+1 bits).
  always_comb begin
    digit_sel  = step[3:2];
    bit_sel    = 2'd3 - step[1:0];
    case (digit_sel)
      2'd0:    shift_k = 3'd4;
      2'd1:    shift_k = 3'd2;
      2'd2:    shift_k = 3'd0;
      default: shift_k = 3'd0;
    endcase
    weight_pos = {1'b0, shift_k} + {2'b00, bit_sel};
    weight     = {{WIDTH{1'b0}}, 1'b1} << weight_pos;
    trial      = {1'b0, rem} - weight;
    borrow     = trial[WIDTH];
    bit_mask   = 4'b0001 << bit_sel;
  end

  // Next-state and working-register update for the IDLE/CALC/DONE sequence.
  always_comb begin
    state_next = state;
    rem_next   = rem;
    step_next  = step;
    dig3_next  = dig3;
    dig2_next  = dig2;
    dig1_next  = dig1;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          rem_next   = in_v;
          step_next  = 4'd0;
          dig3_next  = 4'd0;
          dig2_next  = 4'd0;
          dig1_next  = 4'd0;
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (!borrow) begin
          rem_next = trial[WIDTH-1:0];
          case (digit_sel)
            2'd0:    dig3_next = dig3 | bit_mask;
            2'd1:    dig2_next = dig2 | bit_mask;
            2'd2:    dig1_next = dig1 | bit_mask;
            default: dig1_next = dig1;
          endcase
        end else begin
          rem_next = rem;
        end
        if (step == LAST_STEP) begin
          state_next = DONE;
        end else begin
          step_next = step + 4'd1;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and working registers; reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= '0;
      step  <= 4'd0;
      dig3  <= 4'd0;
      dig2  <= 4'd0;
      dig1  <= 4'd0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
      step  <= step_next;
      dig3  <= dig3_next;
      dig2  <= dig2_next;
      dig1  <= dig1_next;
    end
  end

  // Handshake flags registered from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  // Result registers load only on the final trial and hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3      <= 4'd0;
      s2      <= 4'd0;
      s1      <= 4'd0;
      residue <= '0;
      exact   <= 1'b0;
    end else if (state == CALC && step == LAST_STEP) begin
      s3      <= dig3_next;
      s2      <= dig2_next;
      s1      <= dig1_next;
      residue <= rem_next;
      exact   <= (rem_next == '0);
    end
  end

endmodule
